// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register offsets, STATUS bit positions and
// the bit-level state encoding used by both the transmitter and the receiver.
package uart_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_RXDATA = 4'h8;

    localparam int unsigned STAT_TX_BUSY      = 0;
    localparam int unsigned STAT_RX_VALID     = 1;
    localparam int unsigned STAT_RX_OVERRUN   = 2;
    localparam int unsigned STAT_RX_FRAME_ERR = 3;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronises the async line, samples mid-bit and presents the received
// byte with valid/overrun/framing-error flags that stay set until acknowledged.
module uart_rx #(
    parameter int unsigned ClksPerBit = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    input  logic       ack_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       overrun_o,
    output logic       frame_err_o
);
    import uart_pkg::*;

    localparam int unsigned CntW = $clog2(ClksPerBit);

    logic            sync1_q, sync2_q, prev_q;
    uart_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            ferr_q, ferr_d;
    logic            bit_end, half_end;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        byte_d    = byte_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        ferr_d    = ferr_q;
        bit_end   = (cnt_q == CntW'(ClksPerBit - 1));
        half_end  = (cnt_q == CntW'(ClksPerBit / 2 - 1));

        if (ack_i) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
            ferr_d    = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = StStart;
            end
            StStart: begin
                cnt_d = cnt_q + 1'b1;
                if (half_end) begin
                    // A line that is high again at mid-start was only a glitch.
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? StIdle : StData;
                end
            end
            StData: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = {sync2_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    byte_d  = shreg_q;
                    valid_d = 1'b1;
                    // A same-cycle ack retires the old byte, so only the new one counts.
                    if (ack_i) begin
                        overrun_d = 1'b0;
                        ferr_d    = !sync2_q;
                    end else begin
                        overrun_d = overrun_q | valid_q;
                        ferr_d    = ferr_q | !sync2_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rxd_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign byte_o      = byte_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_periph.sv
// Bus-side UART slot: TXDATA/STATUS/RXDATA registers, 8N1 transmitter with bus
// backpressure while a frame is in flight, and the receiver sub-module.
module uart_periph #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  uart_addr,
    input  logic        uart_wen,
    input  logic [31:0] uart_wdata,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    output logic        uart_txd,
    input  logic        uart_rxd,
    output logic        rx_irq
);
    import uart_pkg::*;

    localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
    localparam int unsigned CntW       = $clog2(ClksPerBit);

    uart_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            txd_q, txd_d;
    logic            tx_busy, bit_end;
    logic            rx_ack, rx_valid, rx_overrun, rx_frame_err;
    logic [7:0]      rx_byte;
    logic [3:0]      status;
    logic            unused_wdata;

    assign unused_wdata = ^uart_wdata[31:8];
    assign tx_busy      = (state_q != StIdle);
    assign bit_end      = (cnt_q == CntW'(ClksPerBit - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (uart_wen && (uart_addr == UART_TXDATA)) begin
                    shreg_d = uart_wdata[7:0];
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = {1'b1, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is registered from the next state so the pin is glitch-free.
        unique case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shreg_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

    assign rx_ack = uart_wen && (uart_addr == UART_RXDATA);

    uart_rx #(
        .ClksPerBit(ClksPerBit)
    ) u_rx (
        .clk_i       (clk),
        .rst_i       (rst),
        .rxd_i       (uart_rxd),
        .ack_i       (rx_ack),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .overrun_o   (rx_overrun),
        .frame_err_o (rx_frame_err)
    );

    always_comb begin
        status                    = '0;
        status[STAT_TX_BUSY]      = tx_busy;
        status[STAT_RX_VALID]     = rx_valid;
        status[STAT_RX_OVERRUN]   = rx_overrun;
        status[STAT_RX_FRAME_ERR] = rx_frame_err;
        unique case (uart_addr)
            UART_STATUS: uart_rdata = {28'b0, status};
            UART_RXDATA: uart_rdata = {24'b0, rx_byte};
            default:     uart_rdata = '0;
        endcase
    end

    assign uart_ready = !(tx_busy && (uart_addr == UART_TXDATA));
    assign uart_txd   = txd_q;
    assign rx_irq     = rx_valid;

endmodule

// File: tb/tb_uart_periph.sv
// Randomised bench for uart_periph: a line-level TX monitor scores frames against a queue
// of written bytes, and an abstract RX flag model scores the register view.
module tb_uart_periph;
    import uart_pkg::*;

    localparam int unsigned CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  uart_addr = 4'h4;
    logic        wen_req = 1'b0;
    logic        uart_wen;
    logic [31:0] uart_wdata = '0;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_txd;
    logic        uart_rxd = 1'b1;
    logic        rx_irq;

    int          checks = 0;
    int          passes = 0;
    logic [7:0]  tx_q[$];
    bit          mon_en = 1'b1;

    bit          m_valid = 0, m_ovr = 0, m_ferr = 0;
    logic [7:0]  m_byte = '0;

    // The bus only raises the write strobe once the slave is ready.
    assign uart_wen = wen_req & uart_ready;

    uart_periph #(
        .CLK_HZ(1_000_000),
        .BAUD  (100_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_addr  (uart_addr),
        .uart_wen   (uart_wen),
        .uart_wdata (uart_wdata),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .uart_txd   (uart_txd),
        .uart_rxd   (uart_rxd),
        .rx_irq     (rx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic check_reg(input string name, input logic [3:0] addr, input logic [31:0] exp);
        uart_addr = addr;
        #1;
        check(name, uart_rdata, exp);
    endtask

    function automatic logic [31:0] model_status();
        return {28'b0, m_ferr, m_ovr, m_valid, 1'b0};
    endfunction

    task automatic check_rx_model(input string name);
        check({name, "_status"}, {28'b0, rx_irq, 3'b0}, {28'b0, m_valid, 3'b0});
        check_reg({name, "_stat"}, UART_STATUS, model_status());
        check_reg({name, "_data"}, UART_RXDATA, {24'b0, m_byte});
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        uart_addr  = addr;
        uart_wdata = data;
        wen_req    = 1'b1;
        tick();
        wen_req    = 1'b0;
    endtask

    // Returns the number of cycles the store was held off by backpressure.
    task automatic tx_send(input logic [7:0] b, output int stall);
        uart_addr  = UART_TXDATA;
        uart_wdata = {$urandom, b} >> 0;
        uart_wdata[7:0] = b;
        wen_req    = 1'b1;
        stall      = 0;
        #1;
        while (!uart_ready && stall < 300) begin
            stall++;
            tick();
        end
        if (!uart_ready) check("tx_ready_timeout", 32'(uart_ready), 32'd1);
        tick();
        wen_req = 1'b0;
        tx_q.push_back(b);
    endtask

    task automatic tx_drain();
        int n = 0;
        while (tx_q.size() != 0 && n < 3000) begin
            n++;
            tick();
        end
        check("tx_drain", tx_q.size(), 0);
        repeat (CPB) tick();
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            repeat (CPB) tick();
        end
        uart_rxd = 1'b1;
        if (m_valid) m_ovr = 1;
        m_valid = 1;
        m_byte  = b;
        if (!stop) m_ferr = 1;
    endtask

    task automatic rx_ack();
        bus_write(UART_RXDATA, $urandom);
        m_valid = 0;
        m_ovr   = 0;
        m_ferr  = 0;
    endtask

    // Frame decoder on the TX pin, sampling at the middle of each bit period.
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] d;
        logic [7:0] exp;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !uart_txd && mon_en) begin
                repeat (4) @(negedge clk);
                check("tx_start_bit", 32'(uart_txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = uart_txd;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", 32'(uart_txd), 32'd1);
                if (tx_q.size() == 0) begin
                    check("tx_unexpected_frame", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    exp = tx_q.pop_front();
                    check("tx_frame_byte", 32'(d), 32'(exp));
                end
            end
            prev = uart_txd;
        end
    end

    initial begin : stimulus
        int         stall;
        logic [7:0] b;
        bit         s;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_irq", 32'(rx_irq), 32'd0);
        uart_addr = UART_TXDATA;
        #1;
        check("rst_ready", 32'(uart_ready), 32'd1);
        check_reg("rst_status", UART_STATUS, 32'h0);
        tick();
        check_reg("rst_rxdata", UART_RXDATA, 32'h0);

        // 0x55 frame: exact bit boundaries and busy window
        tx_send(8'h55, stall);
        check("tx55_first_low", 32'(uart_txd), 32'd0);
        check_reg("tx55_busy_n1", UART_STATUS, 32'h1);
        repeat (9) tick();
        check("tx55_start_end", 32'(uart_txd), 32'd0);
        tick();
        check("tx55_bit0", 32'(uart_txd), 32'd1);
        repeat (89) tick();
        check_reg("tx55_busy_n100", UART_STATUS, 32'h1);
        tick();
        check_reg("tx55_idle_n101", UART_STATUS, 32'h0);
        tx_drain();

        // back-to-back stores with the second one stalled
        tx_send(8'hA3, stall);
        tx_send(8'h12, stall);
        check("tx_stall_cycles", stall, 100);
        tx_drain();

        // RX: single byte, ack
        send_rx(8'hC4, 1'b1);
        check_rx_model("rx_c4");
        check_reg("rx_c4_stat_lit", UART_STATUS, 32'h2);
        rx_ack();
        check_reg("rx_ack_clear", UART_STATUS, 32'h0);

        // RX overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check_rx_model("rx_ovr");
        check_reg("rx_ovr_lit", UART_STATUS, 32'h6);
        rx_ack();

        // framing error still delivers the byte
        send_rx(8'h5E, 1'b0);
        repeat (5) tick();
        check_rx_model("rx_ferr");
        rx_ack();

        // 3-cycle glitch must not start a frame
        uart_rxd = 1'b0;
        repeat (3) tick();
        uart_rxd = 1'b1;
        repeat (120) tick();
        check_reg("rx_glitch", UART_STATUS, 32'h0);

        // randomised RX with random acks and stop bits
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) rx_ack();
            send_rx(b, s);
            repeat (5) tick();
            check_rx_model("rx_rand");
        end

        // randomised TX burst
        for (int k = 0; k < 4; k++) begin
            tx_send(8'($urandom), stall);
        end
        tx_drain();

        // reset in the middle of a frame
        mon_en = 1'b0;
        bus_write(UART_TXDATA, 32'h5A);
        repeat (39) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_valid = 0;
        m_ovr   = 0;
        m_ferr  = 0;
        m_byte  = '0;
        check("rst_mid_txd", 32'(uart_txd), 32'd1);
        check_reg("rst_mid_status", UART_STATUS, 32'h0);
        check_rx_model("rst_mid_rx");
        tick();
        mon_en = 1'b1;
        tick();
        tx_send(8'h3C, stall);
        check("rst_after_stall", stall, 0);
        tx_drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
